// File: rtl/ex_div_unit_pkg.sv
// Shared constants, FSM encoding and helpers for the EX-stage divider.
package ex_div_unit_pkg;

    localparam logic [5:0]  FUNCT_DIV  = 6'h1A;
    localparam logic [5:0]  FUNCT_DIVU = 6'h1B;
    localparam int unsigned DIV_ITER   = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// Pipeline <-> divider port bundle: request side is master, divider is slave.
interface ex_div_unit_if #(
    parameter int unsigned DATA_W = 32
);

    logic              start;
    logic [5:0]        funct;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              flush;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, funct, dividend, divisor, flush,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, funct, dividend, divisor, flush,
        output stall, done, hi, lo
    );

endinterface

// File: rtl/ex_div_unit_iter_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_iter_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic            fits;

    // The shifted remainder needs one extra bit; the difference always fits back in DATA_W.
    always_comb begin
        shifted = {rem_i, quo_i[DATA_W-1]};
        fits    = shifted >= {1'b0, dvs_i};
        rem_o   = fits ? (shifted[DATA_W-1:0] - dvs_i) : shifted[DATA_W-1:0];
        quo_o   = {quo_i[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle EX-stage divider (div/divu), 32 iterations, stalls the front of the pipe.
// Define DIV_SIGNED_EN to make funct 0x1A a signed divide; otherwise everything is unsigned.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_div_unit_if.slave  div_if
);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [DATA_W-1:0] rem_d, quo_d;
    logic [DATA_W-1:0] hi_q, lo_q, hi_d, lo_d;
    logic [DATA_W-1:0] dvd_mag, dvs_mag;
    logic              done_q;
    logic              accept;

    assign accept        = (state_q == ST_IDLE) && div_if.start && !div_if.flush;
    assign div_if.stall  = accept || (state_q == ST_CALC);
    assign div_if.done   = done_q;
    assign div_if.hi     = hi_q;
    assign div_if.lo     = lo_q;

    div_iter_step #(.DATA_W(DATA_W)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

`ifdef DIV_SIGNED_EN
    logic              sgn_d;
    logic              qneg_q, rneg_q, dz_q;
    logic [DATA_W-1:0] dvd_q;

    assign sgn_d   = (div_if.funct == FUNCT_DIV);
    assign dvd_mag = sgn_d ? mag32(div_if.dividend) : div_if.dividend;
    assign dvs_mag = sgn_d ? mag32(div_if.divisor)  : div_if.divisor;

    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            dvd_q  <= '0;
        end else if (accept) begin
            qneg_q <= sgn_d && (div_if.dividend[DATA_W-1] ^ div_if.divisor[DATA_W-1]);
            rneg_q <= sgn_d && div_if.dividend[DATA_W-1];
            dz_q   <= (div_if.divisor == '0);
            dvd_q  <= div_if.dividend;
        end
    end

    // Divide-by-zero bypasses the sign fixup so lo=all-ones and hi=raw dividend.
    always_comb begin
        lo_d = dz_q ? '1    : (qneg_q ? -quo_q : quo_q);
        hi_d = dz_q ? dvd_q : (rneg_q ? -rem_q : rem_q);
    end
`else
    logic funct_unused;

    assign funct_unused = ^div_if.funct;
    assign dvd_mag      = div_if.dividend;
    assign dvs_mag      = div_if.divisor;
    assign lo_d         = quo_q;
    assign hi_d         = rem_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rem_q   <= '0;
                        quo_q   <= dvd_mag;
                        dvs_q   <= dvs_mag;
                        cnt_q   <= '0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (div_if.flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (!div_if.flush) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
